// File: rtl/spi_shift_unit_pkg.sv
// Shared types and width helpers for the SPI shift/rotate coprocessor.
// Frame widths are derived from the operand width so every file agrees on the layout.
package spi_shift_unit_pkg;

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_ROR = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } shift_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_COMPUTE,
        ST_READY,
        ST_SEND
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic ACK_BIT   = 1'b0;

    function automatic int amt_width(input int data_width);
        return $clog2(data_width);
    endfunction

    // Request: [2:0] opcode, operand, then amount in the top bits.
    function automatic int req_width(input int data_width);
        return 3 + data_width + $clog2(data_width);
    endfunction

    // Response: result bits followed by one status bit.
    function automatic int rsp_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/spi_shift_unit_shift_core.sv
// Combinational shift/rotate datapath: five modes, invalid opcodes give zero plus a flag.
// Rotates use a doubled operand so no shift by DATA_WIDTH - amount is ever formed.
module shift_core
    import spi_shift_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int AMT_W      = $clog2(DATA_WIDTH)
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand,
    input  logic [AMT_W-1:0]      amount,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  invalid
);

    logic [2*DATA_WIDTH-1:0] dbl;

    always_comb begin
        dbl     = {operand, operand};
        result  = '0;
        invalid = 1'b0;
        case (op)
            OP_ROL:  result = DATA_WIDTH'((dbl << amount) >> DATA_WIDTH);
            OP_ROR:  result = DATA_WIDTH'(dbl >> amount);
            OP_SLL:  result = operand << amount;
            OP_SRL:  result = operand >> amount;
            OP_SRA:  result = $unsigned($signed(operand) >>> amount);
            default: begin
                result  = '0;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/spi_shift_unit.sv
// SPI slave front end: receives opcode/operand/amount LSB first, computes, returns result+status.
// miso is released to high-Z whenever this unit's select line is high.
module spi_shift_unit
    import spi_shift_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NSS_WIDTH  = 4,
    parameter int NSS_INDEX  = 0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NSS_WIDTH-1:0] spi_nss,
    input  logic                 spi_mosi,
    output wire                  spi_miso,
    output logic                 o_busy
);

    localparam int AMT_W = amt_width(DATA_WIDTH);
    localparam int REQ_W = req_width(DATA_WIDTH);
    localparam int RSP_W = rsp_width(DATA_WIDTH);
    localparam int CNT_W = $clog2(REQ_W);
    localparam logic [CNT_W-1:0]     LAST_REQ = CNT_W'(REQ_W - 1);
    localparam logic [CNT_W-1:0]     LAST_RSP = CNT_W'(RSP_W - 1);
    localparam logic [NSS_WIDTH-1:0] SEL_MASK = NSS_WIDTH'(1) << NSS_INDEX;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [REQ_W-1:0]      req;
    logic [RSP_W-1:0]      rsp;
    logic                  clr;
    logic                  selected;
    logic                  miso_d;
    logic [DATA_WIDTH-1:0] result;
    logic                  invalid;

    // Masked reduction keeps every select bit in the expression.
    assign selected = |(~spi_nss & SEL_MASK);
    assign spi_miso = selected ? miso_d : 1'bz;
    assign o_busy   = (state != ST_IDLE);

    shift_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .AMT_W     (AMT_W)
    ) u_core (
        .op     (req[2:0]),
        .operand(req[3 +: DATA_WIDTH]),
        .amount (req[REQ_W-1 -: AMT_W]),
        .result (result),
        .invalid(invalid)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr       = 1'b0;
        miso_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (selected && spi_mosi == START_BIT) begin
                    state_nxt = ST_RECV;
                    cnt_nxt   = '0;
                end
            end
            ST_RECV: begin
                if (!selected) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    clr       = 1'b1;
                end else if (cnt == LAST_REQ) begin
                    state_nxt = ST_COMPUTE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            // A deselect here still lets the result register; the unit then idles.
            ST_COMPUTE: begin
                state_nxt = selected ? ST_READY : ST_IDLE;
            end
            ST_READY: begin
                miso_d = 1'b1;
                if (!selected) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    clr       = 1'b1;
                end else if (spi_mosi == ACK_BIT) begin
                    state_nxt = ST_SEND;
                    cnt_nxt   = '0;
                end
            end
            ST_SEND: begin
                miso_d = |(rsp & (RSP_W'(1) << cnt));
                if (!selected) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    clr       = 1'b1;
                end else if (cnt == LAST_RSP) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            req <= '0;
            rsp <= '0;
        end else if (clr) begin
            req <= '0;
            rsp <= '0;
        end else begin
            if (state == ST_RECV)
                req[cnt] <= spi_mosi;
            if (state == ST_COMPUTE)
                rsp <= {invalid, result};
        end
    end

endmodule

// File: tb/tb_spi_shift_unit.sv
// Bench for spi_shift_unit: two 8-bit units sharing one bus plus a 16-bit unit,
// directed and random frames checked cycle by cycle against a bit-serial reference model.
module tb_spi_shift_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] nss8 = 4'hF;
    logic [3:0] nss16 = 4'hF;
    logic       mosi8 = 1'b0;
    logic       mosi16 = 1'b0;
    wire        miso_a, miso_b, miso_c;
    logic       busy_a, busy_b, busy_c;

    pullup pu_a (miso_a);
    pullup pu_b (miso_b);
    pullup pu_c (miso_c);

    always #5 clk = ~clk;

    spi_shift_unit #(.DATA_WIDTH(8), .NSS_WIDTH(4), .NSS_INDEX(0)) u_a (
        .i_clock(clk), .i_reset(rst_n), .spi_nss(nss8), .spi_mosi(mosi8),
        .spi_miso(miso_a), .o_busy(busy_a));
    spi_shift_unit #(.DATA_WIDTH(8), .NSS_WIDTH(4), .NSS_INDEX(2)) u_b (
        .i_clock(clk), .i_reset(rst_n), .spi_nss(nss8), .spi_mosi(mosi8),
        .spi_miso(miso_b), .o_busy(busy_b));
    spi_shift_unit #(.DATA_WIDTH(16), .NSS_WIDTH(4), .NSS_INDEX(1)) u_c (
        .i_clock(clk), .i_reset(rst_n), .spi_nss(nss16), .spi_mosi(mosi16),
        .spi_miso(miso_c), .o_busy(busy_c));

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    logic exp_busy [3];
    logic exp_miso [3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic sel_of(input int d);
        case (d)
            0:       return !nss8[0];
            1:       return !nss8[2];
            default: return !nss16[1];
        endcase
    endfunction

    function automatic logic miso_of(input int d);
        case (d)
            0:       return miso_a;
            1:       return miso_b;
            default: return miso_c;
        endcase
    endfunction

    function automatic logic busy_of(input int d);
        case (d)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    // Reference: apply the requested mode one bit position at a time, amount times.
    function automatic logic [32:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] x, input int amt);
        logic [31:0] r, mask;
        mask = (32'h1 << w) - 32'h1;
        r = x & mask;
        if (op > 3'd4) return {1'b1, 32'h0};
        for (int k = 0; k < amt; k++) begin
            case (op)
                3'd0:    r = ((r << 1) | (r >> (w - 1))) & mask;
                3'd1:    r = (r >> 1) | ((r & 32'h1) << (w - 1));
                3'd2:    r = (r << 1) & mask;
                3'd3:    r = r >> 1;
                default: r = (r >> 1) | (r & (32'h1 << (w - 1)));
            endcase
        end
        return {1'b0, r};
    endfunction

    // Idle units drive 0 when selected; unselected ones float and read back as the pull-up.
    task automatic idle_exp();
        for (int d = 0; d < 3; d++) begin
            exp_busy[d] = 1'b0;
            exp_miso[d] = sel_of(d) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sel(input int which, input bit on);
        nss8  = 4'hF;
        nss16 = 4'hF;
        if (on) begin
            case (which)
                0:       nss8[0]  = 1'b0;
                1:       nss8[2]  = 1'b0;
                default: nss16[1] = 1'b0;
            endcase
        end
    endtask

    task automatic set_mosi(input int which, input logic v);
        if (which == 2) mosi16 = v;
        else            mosi8  = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            drive_sel(0, 1'b0);
            idle_exp();
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("busy%0d", d), 32'(busy_of(d)), 32'(exp_busy[d]));
                check($sformatf("miso%0d", d), 32'(miso_of(d)), 32'(exp_miso[d]));
            end
        end
    end

    // abort_bits >= 0 deselects after that many request bits; reset_at >= 0 pulses reset in SEND.
    task automatic do_frame(input int which, input logic [2:0] op, input logic [31:0] x,
                            input int amt, input int ack_wait, input int abort_bits,
                            input int reset_at, output logic [31:0] res, output logic st);
        int          w, aw, reqw, rspw;
        logic [63:0] req;
        logic [32:0] m;
        logic [31:0] rsp, got;
        w    = (which == 2) ? 16 : 8;
        aw   = (which == 2) ? 4 : 3;
        reqw = 3 + w + aw;
        rspw = w + 1;
        m    = model(w, op, x, amt);
        rsp  = m[31:0];
        rsp[w] = m[32];
        req  = 64'(op) | (64'(x) << 3) | (64'(amt) << (3 + w));
        res  = '0;
        st   = 1'b0;
        got  = '0;
        step();
        drive_sel(which, 1'b1);
        set_mosi(which, 1'b1);
        idle_exp();
        for (int i = 0; i < reqw; i++) begin
            step();
            if (i == abort_bits) begin
                drive_sel(which, 1'b0);
                set_mosi(which, 1'($urandom % 2));
                idle_exp();
                exp_busy[which] = 1'b1;
                step();
                idle_exp();
                return;
            end
            set_mosi(which, req[i]);
            idle_exp();
            exp_busy[which] = 1'b1;
        end
        step();
        set_mosi(which, 1'b1);
        idle_exp();
        exp_busy[which] = 1'b1;
        for (int wt = 0; wt <= ack_wait; wt++) begin
            step();
            set_mosi(which, (wt < ack_wait) ? 1'b1 : 1'b0);
            idle_exp();
            exp_busy[which] = 1'b1;
            exp_miso[which] = 1'b1;
        end
        for (int j = 0; j < rspw; j++) begin
            step();
            set_mosi(which, 1'($urandom % 2));
            idle_exp();
            exp_busy[which] = 1'b1;
            exp_miso[which] = rsp[j];
            @(negedge clk);
            got[j] = miso_of(which);
            if (j == reset_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("reset_busy", 32'(busy_of(which)), 32'd0);
                check("reset_miso", 32'(miso_of(which)), 32'd0);
                @(negedge clk);
                #1;
                rst_n = 1'b1;
                drive_sel(which, 1'b0);
                idle_exp();
                return;
            end
        end
        for (int k = 0; k < w; k++) res[k] = got[k];
        st = got[w];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, expected $finish before 1ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, x;
        logic        st;
        logic [32:0] m;
        int          which, w, amt;
        logic [2:0]  op;

        idle_exp();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_busy%0d", d), 32'(busy_of(d)), 32'd0);
            check($sformatf("rst_miso_z%0d", d), 32'(miso_of(d)), 32'd1);
        end
        drive_sel(0, 1'b1);
        #1;
        check("rst_miso_sel", 32'(miso_a), 32'd0);
        drive_sel(0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle_exp();
        chk_en = 1'b1;

        m = model(8, 3'd0, 32'h96, 3);   check("model_rol", m[31:0], 32'hB4);
        m = model(8, 3'd1, 32'h96, 3);   check("model_ror", m[31:0], 32'hD2);
        m = model(8, 3'd4, 32'h96, 2);   check("model_sra", m[31:0], 32'hE5);
        m = model(16, 3'd1, 32'h8001, 1); check("model_ror16", m[31:0], 32'hC000);

        do_frame(0, 3'd0, 32'h96, 3, 0, -1, -1, res, st);
        check("rol_res", res, 32'hB4); check("rol_st", 32'(st), 32'd0);
        do_frame(0, 3'd1, 32'h96, 3, 2, -1, -1, res, st);
        check("ror_res", res, 32'hD2);
        do_frame(0, 3'd4, 32'h96, 2, 1, -1, -1, res, st);
        check("sra_res", res, 32'hE5);
        do_frame(0, 3'd3, 32'h96, 2, 0, -1, -1, res, st);
        check("srl_res", res, 32'h25);
        do_frame(0, 3'd2, 32'h96, 0, 0, -1, -1, res, st);
        check("sll0_res", res, 32'h96); check("sll0_st", 32'(st), 32'd0);
        do_frame(0, 3'd7, 32'hFF, 0, 0, -1, -1, res, st);
        check("inv_res", res, 32'h00); check("inv_st", 32'(st), 32'd1);

        do_frame(0, 3'd0, 32'h01, 1, 0, 5, -1, res, st);
        idle(2);
        do_frame(0, 3'd0, 32'h01, 1, 0, -1, -1, res, st);
        check("after_abort_res", res, 32'h02);

        do_frame(1, 3'd0, 32'h96, 3, 1, -1, -1, res, st);
        check("unit_b_rol", res, 32'hB4);

        do_frame(2, 3'd1, 32'h8001, 1, 0, -1, -1, res, st);
        check("ror16_res", res, 32'hC000);
        do_frame(2, 3'd0, 32'h1234, 4, 0, -1, 5, res, st);
        idle(2);
        do_frame(2, 3'd4, 32'h8421, 3, 0, -1, -1, res, st);
        check("after_reset_sra16", res, 32'hF084);

        for (int n = 0; n < 60; n++) begin
            which = int'($urandom % 3);
            w     = (which == 2) ? 16 : 8;
            op    = 3'($urandom % 8);
            x     = $urandom & ((32'h1 << w) - 32'h1);
            amt   = int'($urandom % w);
            do_frame(which, op, x, amt, int'($urandom % 3), -1, -1, res, st);
            m = model(w, op, x, amt);
            check($sformatf("rand%0d_res", n), res, m[31:0]);
            check($sformatf("rand%0d_st", n), 32'(st), 32'(m[32]));
            if ($urandom % 2 == 1) idle(1);
        end

        idle(2);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
